// File: rtl/disk_pkg.sv
// Shared types for the disk SDRAM arbiter.
//   client_id_t  : 2-bit requester id (host image loader, drive 1, drive 2)
//   arb_state_t  : transaction FSM state
//   client_onehot: maps a client id to its ack bit position
package disk_pkg;

   typedef logic [1:0] client_id_t;

   localparam client_id_t CLIENT_HOST   = 2'd0;
   localparam client_id_t CLIENT_DRIVE1 = 2'd1;
   localparam client_id_t CLIENT_DRIVE2 = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   function automatic logic [2:0] client_onehot(input client_id_t id);
      logic [2:0] oh;
      case (id)
         CLIENT_DRIVE1: oh = 3'b010;
         CLIENT_DRIVE2: oh = 3'b100;
         default:       oh = 3'b001;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/disk_arb_select.sv
// Combinational winner selection for the disk SDRAM arbiter.
//   req        : per-client request levels (bit 0 host, bits 1/2 drives)
//   last_drive : drive that received the most recent drive grant
//   host_run   : consecutive host grants made while a drive was waiting
//   winner     : selected client id
//   valid      : at least one client is requesting
module disk_arb_select
   import disk_pkg::*;
#(
   parameter int HOST_BURST = 4,
   parameter int RUN_W      = $clog2(HOST_BURST + 1)
) (
   input  logic [2:0]       req,
   input  client_id_t       last_drive,
   input  logic [RUN_W-1:0] host_run,
   output client_id_t       winner,
   output logic             valid
);

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(HOST_BURST);

   logic       drive_req;
   client_id_t other_drive;

   always_comb begin
      drive_req   = req[1] | req[2];
      other_drive = (last_drive == CLIENT_DRIVE1) ? CLIENT_DRIVE2 : CLIENT_DRIVE1;
      valid       = |req;
      winner      = CLIENT_HOST;
      // Host keeps priority until it has used up its burst allowance
      // against a waiting drive; drives then alternate.
      if (req[0] && (!drive_req || host_run < RUN_MAX)) begin
         winner = CLIENT_HOST;
      end else if (req[other_drive]) begin
         winner = other_drive;
      end else if (req[last_drive]) begin
         winner = last_drive;
      end
   end

endmodule

// File: rtl/disk_sdram_arbiter.sv
// Shares the disk SDRAM port between the PicoSoC image loader (client 0)
// and Disk II drives 1 and 2 (clients 1, 2). One transaction at a time is
// latched into command registers, presented to the SDRAM port, and
// completed with a one-cycle ack to the granted client. Transactions that
// stall for TIMEOUT_CYCLES are aborted with err_o.
// Ports:
//   clk_logic, system_reset        : clock, async active-high reset
//   req_i/we_i/addr_i/wdata_i/dqm_i: per-client request (client i in slice i)
//   ack_o, err_o, rdata_o          : completion pulse, timeout flag, read data
//   ctrl_*_o                       : command to the SDRAM port
//   ctrl_ready_i, ctrl_q_i,
//   ctrl_q_valid_i                 : SDRAM accept and read return
module disk_sdram_arbiter
   import disk_pkg::*;
#(
   parameter int ADDR_WIDTH     = 21,
   parameter int DATA_WIDTH     = 32,
   parameter int DQM_WIDTH      = 4,
   parameter int HOST_BURST     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_logic,
   input  logic                    system_reset,
   input  logic [2:0]              req_i,
   input  logic [2:0]              we_i,
   input  logic [3*ADDR_WIDTH-1:0] addr_i,
   input  logic [3*DATA_WIDTH-1:0] wdata_i,
   input  logic [3*DQM_WIDTH-1:0]  dqm_i,
   output logic [2:0]              ack_o,
   output logic                    err_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    ctrl_req_o,
   output logic                    ctrl_we_o,
   output logic [ADDR_WIDTH-1:0]   ctrl_addr_o,
   output logic [DATA_WIDTH-1:0]   ctrl_data_o,
   output logic [DQM_WIDTH-1:0]    ctrl_dqm_o,
   input  logic                    ctrl_ready_i,
   input  logic [DATA_WIDTH-1:0]   ctrl_q_i,
   input  logic                    ctrl_q_valid_i
);

   localparam int RUN_W   = $clog2(HOST_BURST + 1);
   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(HOST_BURST);
   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

   // Reset asserts asynchronously but releases two clocks after
   // system_reset falls, so no flop leaves reset near a clock edge.
   logic [1:0] rst_pipe;
   logic       rst;

   always_ff @(posedge clk_logic or posedge system_reset) begin
      if (system_reset) begin
         rst_pipe <= 2'b11;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b0};
      end
   end

   assign rst = rst_pipe[1];

   arb_state_t              state;
   client_id_t              grant;
   client_id_t              last_drive;
   logic [RUN_W-1:0]        host_run;
   logic [TIMER_W-1:0]      timer;
   logic                    cmd_we;
   logic [ADDR_WIDTH-1:0]   cmd_addr;
   logic [DATA_WIDTH-1:0]   cmd_data;
   logic [DQM_WIDTH-1:0]    cmd_dqm;
   logic                    err;
   logic [DATA_WIDTH-1:0]   rdata;

   client_id_t              winner;
   logic                    win_valid;
   logic                    drive_req;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic [DQM_WIDTH-1:0]    sel_dqm;

   disk_arb_select #(
      .HOST_BURST (HOST_BURST),
      .RUN_W      (RUN_W)
   ) u_select (
      .req        (req_i),
      .last_drive (last_drive),
      .host_run   (host_run),
      .winner     (winner),
      .valid      (win_valid)
   );

   always_comb begin
      drive_req = req_i[1] | req_i[2];
      sel_we    = we_i[winner];
      case (winner)
         CLIENT_DRIVE1: begin
            sel_addr = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = wdata_i[DATA_WIDTH +: DATA_WIDTH];
            sel_dqm  = dqm_i[DQM_WIDTH +: DQM_WIDTH];
         end
         CLIENT_DRIVE2: begin
            sel_addr = addr_i[2*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = wdata_i[2*DATA_WIDTH +: DATA_WIDTH];
            sel_dqm  = dqm_i[2*DQM_WIDTH +: DQM_WIDTH];
         end
         default: begin
            sel_addr = addr_i[0 +: ADDR_WIDTH];
            sel_data = wdata_i[0 +: DATA_WIDTH];
            sel_dqm  = dqm_i[0 +: DQM_WIDTH];
         end
      endcase
   end

   always_ff @(posedge clk_logic or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= CLIENT_HOST;
         last_drive <= CLIENT_DRIVE2;
         host_run   <= '0;
         timer      <= '0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_data   <= '0;
         cmd_dqm    <= '0;
         err        <= 1'b0;
         rdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  grant    <= winner;
                  cmd_we   <= sel_we;
                  cmd_addr <= sel_addr;
                  cmd_data <= sel_data;
                  cmd_dqm  <= sel_dqm;
                  err      <= 1'b0;
                  timer    <= '0;
                  state    <= ISSUE;
                  if (winner == CLIENT_HOST) begin
                     // Only host grants that make a drive wait count
                     // against the burst allowance.
                     if (!drive_req) begin
                        host_run <= '0;
                     end else if (host_run < RUN_MAX) begin
                        host_run <= host_run + RUN_W'(1);
                     end
                  end else begin
                     host_run   <= '0;
                     last_drive <= winner;
                  end
               end
            end
            ISSUE: begin
               timer <= timer + TIMER_W'(1);
               // A real completion in the last allowed cycle wins over
               // the timeout.
               if (ctrl_ready_i) begin
                  if (cmd_we) begin
                     state <= DONE;
                  end else if (ctrl_q_valid_i) begin
                     rdata <= ctrl_q_i;
                     state <= DONE;
                  end else begin
                     state <= WAIT_RD;
                  end
               end else if (timer == TIMER_MAX) begin
                  err   <= 1'b1;
                  state <= DONE;
               end
            end
            WAIT_RD: begin
               timer <= timer + TIMER_W'(1);
               if (ctrl_q_valid_i) begin
                  rdata <= ctrl_q_i;
                  state <= DONE;
               end else if (timer == TIMER_MAX) begin
                  err   <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign ctrl_req_o  = (state == ISSUE);
   assign ctrl_we_o   = cmd_we;
   assign ctrl_addr_o = cmd_addr;
   assign ctrl_data_o = cmd_data;
   assign ctrl_dqm_o  = cmd_dqm;
   assign ack_o       = (state == DONE) ? client_onehot(grant) : 3'b000;
   assign err_o       = (state == DONE) & err;
   assign rdata_o     = rdata;

endmodule

// File: tb/tb_disk_sdram_arbiter.sv
// Directed bench for disk_sdram_arbiter (TIMEOUT_CYCLES = 16, HOST_BURST = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_disk_sdram_arbiter;

   localparam int AW = 21;
   localparam int DW = 32;
   localparam int MW = 4;

   logic              clk_logic;
   logic              system_reset;
   logic [2:0]        req_i;
   logic [2:0]        we_i;
   logic [3*AW-1:0]   addr_i;
   logic [3*DW-1:0]   wdata_i;
   logic [3*MW-1:0]   dqm_i;
   logic [2:0]        ack_o;
   logic              err_o;
   logic [DW-1:0]     rdata_o;
   logic              ctrl_req_o;
   logic              ctrl_we_o;
   logic [AW-1:0]     ctrl_addr_o;
   logic [DW-1:0]     ctrl_data_o;
   logic [MW-1:0]     ctrl_dqm_o;
   logic              ctrl_ready_i;
   logic [DW-1:0]     ctrl_q_i;
   logic              ctrl_q_valid_i;

   int total = 0;
   int bad   = 0;

   disk_sdram_arbiter #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .DQM_WIDTH      (MW),
      .HOST_BURST     (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_logic      (clk_logic),
      .system_reset   (system_reset),
      .req_i          (req_i),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .dqm_i          (dqm_i),
      .ack_o          (ack_o),
      .err_o          (err_o),
      .rdata_o        (rdata_o),
      .ctrl_req_o     (ctrl_req_o),
      .ctrl_we_o      (ctrl_we_o),
      .ctrl_addr_o    (ctrl_addr_o),
      .ctrl_data_o    (ctrl_data_o),
      .ctrl_dqm_o     (ctrl_dqm_o),
      .ctrl_ready_i   (ctrl_ready_i),
      .ctrl_q_i       (ctrl_q_i),
      .ctrl_q_valid_i (ctrl_q_valid_i)
   );

   initial begin
      clk_logic = 1'b0;
      forever #5 clk_logic = ~clk_logic;
   end

   task automatic tick();
      @(negedge clk_logic);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SDRAM side for a write: wait (bounded) for the command, accept it at
   // once, and return what the DONE cycle shows.
   task automatic serve(output logic [2:0] ack, output logic err, output logic [AW-1:0] adr);
      int n;
      n = 0;
      while (ctrl_req_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("cmd_seen", ctrl_req_o, 1'b1);
      adr          = ctrl_addr_o;
      ctrl_ready_i = 1'b1;
      tick();
      ctrl_ready_i = 1'b0;
      ack          = ack_o;
      err          = err_o;
   endtask

   logic [2:0]    a;
   logic          e;
   logic [AW-1:0] ad;
   int            cnt;
   bit            seen;
   logic [2:0]    fair_exp  [4]  = '{3'b010, 3'b100, 3'b010, 3'b100};
   logic [2:0]    burst_exp [10] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
                                     3'b001, 3'b001, 3'b001, 3'b001, 3'b100};

   initial begin
      system_reset   = 1'b0;
      req_i          = '0;
      we_i           = '0;
      addr_i         = '0;
      wdata_i        = '0;
      dqm_i          = '0;
      ctrl_ready_i   = 1'b0;
      ctrl_q_i       = '0;
      ctrl_q_valid_i = 1'b0;
      #2 system_reset = 1'b1;
      tick();
      tick();

      // Reset state
      chk("rst_ack",   ack_o, 3'b000);
      chk("rst_err",   err_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_req",   ctrl_req_o, 1'b0);
      chk("rst_we",    ctrl_we_o, 1'b0);
      chk("rst_addr",  ctrl_addr_o, 21'h0);
      chk("rst_data",  ctrl_data_o, 32'h0);
      chk("rst_dqm",   ctrl_dqm_o, 4'h0);
      system_reset = 1'b0;
      tick();
      tick();
      tick();

      // Single write from drive 1, ready two cycles after the request rises
      req_i   = 3'b010;
      we_i    = 3'b010;
      addr_i  = {21'h0, 21'h00123, 21'h0};
      wdata_i = {32'h0, 32'hDEADBEEF, 32'h0};
      dqm_i   = '0;
      tick();
      chk("wr_req",   ctrl_req_o, 1'b1);
      chk("wr_addr",  ctrl_addr_o, 21'h00123);
      chk("wr_we",    ctrl_we_o, 1'b1);
      chk("wr_data",  ctrl_data_o, 32'hDEADBEEF);
      chk("wr_dqm",   ctrl_dqm_o, 4'h0);
      tick();
      chk("wr_req2",  ctrl_req_o, 1'b1);
      chk("wr_noack", ack_o, 3'b000);
      ctrl_ready_i = 1'b1;
      tick();
      ctrl_ready_i = 1'b0;
      chk("wr_ack",   ack_o, 3'b010);
      chk("wr_err",   err_o, 1'b0);
      chk("wr_reqlo", ctrl_req_o, 1'b0);
      req_i = '0;
      tick();
      chk("wr_ack1cy", ack_o, 3'b000);
      tick();

      // Read from drive 2 with 5-cycle data latency
      req_i  = 3'b100;
      we_i   = 3'b000;
      addr_i = {21'h1FFFF, 21'h0, 21'h0};
      tick();
      chk("rd_req",  ctrl_req_o, 1'b1);
      chk("rd_addr", ctrl_addr_o, 21'h1FFFF);
      chk("rd_we",   ctrl_we_o, 1'b0);
      ctrl_ready_i = 1'b1;
      tick();
      ctrl_ready_i = 1'b0;
      chk("rd_wait_req", ctrl_req_o, 1'b0);
      chk("rd_wait_ack", ack_o, 3'b000);
      tick();
      tick();
      tick();
      tick();
      ctrl_q_i       = 32'hA5A55A5A;
      ctrl_q_valid_i = 1'b1;
      tick();
      ctrl_q_valid_i = 1'b0;
      ctrl_q_i       = '0;
      chk("rd_ack",   ack_o, 3'b100);
      chk("rd_data",  rdata_o, 32'hA5A55A5A);
      chk("rd_err",   err_o, 1'b0);
      req_i = '0;
      tick();
      chk("rd_ack1cy", ack_o, 3'b000);
      chk("rd_hold",   rdata_o, 32'hA5A55A5A);

      // Drive fairness: both drives request, host idle
      req_i  = 3'b110;
      we_i   = 3'b110;
      addr_i = {21'h00022, 21'h00011, 21'h00000};
      for (int k = 0; k < 4; k++) begin
         serve(a, e, ad);
         chk("fair_ack", a, fair_exp[k]);
         chk("fair_addr", ad, (fair_exp[k] == 3'b010) ? 21'h00011 : 21'h00022);
      end
      req_i = '0;
      tick();

      // Host burst limit with all three requesting
      req_i = 3'b111;
      we_i  = 3'b111;
      for (int k = 0; k < 10; k++) begin
         serve(a, e, ad);
         chk("burst_ack", a, burst_exp[k]);
      end
      req_i = '0;
      tick();

      // Timeout: read from drive 1 never accepted
      req_i  = 3'b010;
      we_i   = 3'b000;
      addr_i = {21'h0, 21'h00200, 21'h0};
      cnt    = 0;
      seen   = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         tick();
         if (ctrl_req_o === 1'b1) cnt++;
         if (ack_o !== 3'b000) seen = 1'b1;
      end
      chk("to_seen",  seen, 1'b1);
      chk("to_cycles", cnt, 16);
      chk("to_ack",   ack_o, 3'b010);
      chk("to_err",   err_o, 1'b1);
      chk("to_req",   ctrl_req_o, 1'b0);
      chk("to_rdata", rdata_o, 32'hA5A55A5A);
      req_i = '0;
      tick();
      chk("to_err1cy", err_o, 1'b0);

      // Normal service after the timeout
      req_i  = 3'b100;
      we_i   = 3'b100;
      addr_i = {21'h00033, 21'h0, 21'h0};
      serve(a, e, ad);
      chk("post_to_ack",  a, 3'b100);
      chk("post_to_err",  e, 1'b0);
      chk("post_to_addr", ad, 21'h00033);
      req_i = '0;
      tick();

      // Reset while waiting for read data
      req_i = 3'b100;
      we_i  = 3'b000;
      tick();
      chk("rr_req", ctrl_req_o, 1'b1);
      ctrl_ready_i = 1'b1;
      tick();
      ctrl_ready_i = 1'b0;
      tick();
      system_reset = 1'b1;
      req_i        = '0;
      #1;
      chk("rr_req_lo", ctrl_req_o, 1'b0);
      chk("rr_ack_lo", ack_o, 3'b000);
      chk("rr_rdata0", rdata_o, 32'h0);
      tick();
      system_reset = 1'b0;
      tick();
      tick();
      tick();
      ctrl_q_i       = 32'h11111111;
      ctrl_q_valid_i = 1'b1;
      tick();
      ctrl_q_valid_i = 1'b0;
      chk("late_q_ack",   ack_o, 3'b000);
      chk("late_q_rdata", rdata_o, 32'h0);
      ctrl_ready_i = 1'b1;
      tick();
      ctrl_ready_i = 1'b0;
      chk("stray_rdy_req", ctrl_req_o, 1'b0);
      chk("stray_rdy_ack", ack_o, 3'b000);

      // After reset, drive 1 goes first
      req_i  = 3'b110;
      we_i   = 3'b110;
      addr_i = {21'h00022, 21'h00011, 21'h00000};
      serve(a, e, ad);
      chk("rr_first", a, 3'b010);
      serve(a, e, ad);
      chk("rr_second", a, 3'b100);
      req_i = '0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
